// File: rtl/ovf_event_tracker.sv
`timescale 1ns/1ps
// ovf_event_tracker
// Watches the 8-bit counter's overflow pulse. It keeps a free-running epoch
// count of wraps. Once armed, it counts hits in a window and raises a level
// irq when the programmed threshold is reached. It also sets a sticky miss
// flag for any overflow that arrives while the irq is still pending.
// Optional build macro: OVF_TRACK_EPOCH_SAT_EN. When it is defined, epoch
// saturates at all-ones. When it is undefined, epoch wraps to zero.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no window open, hits and irq held at zero
// ARMED   | window open, counting overflows toward thresh_q
// FIRED   | threshold reached, irq high until ack/disarm
// 2'b11   | unreachable, recovers to IDLE on the next edge
module ovf_event_tracker #(
   parameter int EPOCH_W  = 16,
   parameter int THRESH_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                overflow,
   input  logic                arm,
   input  logic                disarm,
   input  logic [THRESH_W-1:0] thresh,
   input  logic                irq_ack,
   output logic [EPOCH_W-1:0]  epoch,
   output logic [THRESH_W-1:0] hits,
   output logic                irq,
   output logic [1:0]          state,
   output logic                miss
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_FIRED = 2'b10
   } state_e;

   localparam logic [EPOCH_W-1:0]  EPOCH_ONE  = {{(EPOCH_W-1){1'b0}}, 1'b1};
   localparam logic [EPOCH_W-1:0]  EPOCH_MAX  = {EPOCH_W{1'b1}};
   localparam logic [THRESH_W-1:0] THRESH_ONE = {{(THRESH_W-1){1'b0}}, 1'b1};
   localparam logic [THRESH_W-1:0] THRESH_ZERO = '0;

   state_e              state_q, state_d;
   logic [EPOCH_W-1:0]  epoch_q, epoch_d;
   logic [THRESH_W-1:0] hits_q, hits_d;
   logic [THRESH_W-1:0] thresh_q, thresh_d;
   logic                irq_q, irq_d;
   logic                miss_q, miss_d;
   logic [THRESH_W-1:0] hits_inc;

   assign hits_inc = hits_q + THRESH_ONE;

   // Epoch counter next value, independent of the window FSM.
   always_comb begin
      epoch_d = epoch_q;
`ifdef OVF_TRACK_EPOCH_SAT_EN
      if (overflow && (epoch_q != EPOCH_MAX)) epoch_d = epoch_q + EPOCH_ONE;
`else
      if (overflow) epoch_d = epoch_q + EPOCH_ONE;
`endif
   end

   // Window FSM: next state, hit count, irq and sticky miss.
   always_comb begin
      state_d  = state_q;
      hits_d   = hits_q;
      thresh_d = thresh_q;
      irq_d    = irq_q;
      miss_d   = miss_q;
      case (state_q)
         ST_IDLE: begin
            hits_d = THRESH_ZERO;
            irq_d  = 1'b0;
            if (arm && (thresh != THRESH_ZERO)) begin
               thresh_d = thresh;
               miss_d   = 1'b0;
               state_d  = ST_ARMED;
            end
         end
         ST_ARMED: begin
            irq_d = 1'b0;
            if (disarm) begin
               hits_d  = THRESH_ZERO;
               state_d = ST_IDLE;
            end else if (overflow) begin
               if (hits_inc == thresh_q) begin
                  hits_d  = thresh_q;
                  irq_d   = 1'b1;
                  state_d = ST_FIRED;
               end else begin
                  hits_d = hits_inc;
               end
            end
         end
         ST_FIRED: begin
            irq_d = 1'b1;
            if (disarm) begin
               hits_d  = THRESH_ZERO;
               irq_d   = 1'b0;
               state_d = ST_IDLE;
            end else if (irq_ack) begin
               if (overflow) begin
                  // The overflow that lands on the ack opens the new window.
                  hits_d = THRESH_ONE;
                  if (thresh_q == THRESH_ONE) begin
                     irq_d   = 1'b1;
                     state_d = ST_FIRED;
                  end else begin
                     irq_d   = 1'b0;
                     state_d = ST_ARMED;
                  end
               end else begin
                  hits_d  = THRESH_ZERO;
                  irq_d   = 1'b0;
                  state_d = ST_ARMED;
               end
            end else if (overflow) begin
               miss_d = 1'b1;
            end
         end
         default: begin
            hits_d  = THRESH_ZERO;
            irq_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         epoch_q  <= '0;
         hits_q   <= '0;
         thresh_q <= '0;
         irq_q    <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         epoch_q  <= epoch_d;
         hits_q   <= hits_d;
         thresh_q <= thresh_d;
         irq_q    <= irq_d;
         miss_q   <= miss_d;
      end
   end

   assign epoch = epoch_q;
   assign hits  = hits_q;
   assign irq   = irq_q;
   assign state = state_q;
   assign miss  = miss_q;

endmodule
